// File: rtl/mb_psg_bus_decoder_if.sv
// Bus bundle between the VIA port pair, the PSG bus decoder and the PSG write consumer.
// The master side is the VIA/consumer environment; the slave side is the decoder.
interface mb_psg_bus_decoder_if;
    logic [7:0] port_a_o;
    logic [7:0] port_a_t;
    logic [7:0] port_b_o;
    logic [7:0] port_b_t;
    logic [7:0] data_out;
    logic       data_oe;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       psg_reset;
    logic       overflow;

    modport master (
        output port_a_o, port_a_t, port_b_o, port_b_t, wr_ready,
        input  data_out, data_oe, wr_valid, wr_addr, wr_data, psg_reset, overflow
    );

    modport slave (
        input  port_a_o, port_a_t, port_b_o, port_b_t, wr_ready,
        output data_out, data_oe, wr_valid, wr_addr, wr_data, psg_reset, overflow
    );
endinterface

// File: rtl/mb_psg_bus_decoder.sv
// AY-3-8910 bus decoder for one Mockingboard VIA port pair: debounced bus codes,
// masked 16-register shadow file, read-back onto port A and a 4-deep write FIFO.
module mb_psg_bus_decoder #(
    parameter logic [3:0]  CHIP_SEL      = 4'h0,
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    mb_psg_bus_decoder_if.slave  bus
);
    typedef enum logic [1:0] {
        BUS_INACTIVE = 2'b00,
        BUS_READ     = 2'b01,
        BUS_WRITE    = 2'b10,
        BUS_LATCH    = 2'b11
    } bus_code_t;

    localparam logic [2:0] ACCEPT_COUNT = 3'(STABLE_CYCLES - 1);
    localparam logic [2:0] COUNT_MAX    = 3'd7;

    logic [7:0]  a_eff;
    logic [2:0]  b_eff;
    logic        psg_rst_n;
    bus_code_t   code_in;
    bus_code_t   code_q;
    bus_code_t   acc_code;
    logic        rst_q;
    logic [2:0]  stable_cnt;
    logic [2:0]  stable_cnt_next;
    logic        accept;
    logic        do_latch;
    logic        do_write;
    logic [3:0]  addr;
    logic        sel;
    logic [7:0]  regs [16];
    logic [7:0]  wdata_masked;
    logic [11:0] fifo_mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        pop;
    logic        push;
    logic        drop;
    logic        overflow_q;
    logic        read_active;
    logic        unused_port_b;

    function automatic logic [7:0] reg_mask(input logic [3:0] idx);
        case (idx)
            4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: reg_mask = 8'h1F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    // Undriven VIA pins read as 1 through the pull-ups.
    assign a_eff         = bus.port_a_o | ~bus.port_a_t;
    assign b_eff         = bus.port_b_o[2:0] | ~bus.port_b_t[2:0];
    assign psg_rst_n     = b_eff[2];
    assign code_in       = bus_code_t'(b_eff[1:0]);
    assign unused_port_b = ^{bus.port_b_o[7:3], bus.port_b_t[7:3]};

    always_comb begin
        stable_cnt_next = 3'd0;
        if (code_in == code_q) begin
            stable_cnt_next = (stable_cnt == COUNT_MAX) ? COUNT_MAX : stable_cnt + 3'd1;
        end
    end

    // Saturation keeps a held code from ever hitting the accept count a second time.
    assign accept       = (stable_cnt_next == ACCEPT_COUNT);
    assign do_latch     = accept && (code_in == BUS_LATCH);
    assign do_write     = accept && (code_in == BUS_WRITE) && sel;
    assign wdata_masked = a_eff & reg_mask(addr);

    assign fifo_full = (fifo_count == 3'd4);
    assign pop       = (fifo_count != 3'd0) && bus.wr_ready;
    assign push      = do_write && (!fifo_full || pop);
    assign drop      = do_write && fifo_full && !pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            code_q     <= BUS_INACTIVE;
            rst_q      <= 1'b0;
            stable_cnt <= 3'd0;
            acc_code   <= BUS_INACTIVE;
            addr       <= 4'd0;
            sel        <= 1'b0;
        end else begin
            code_q <= code_in;
            rst_q  <= psg_rst_n;
            if (!psg_rst_n) begin
                stable_cnt <= 3'd0;
                acc_code   <= BUS_INACTIVE;
                addr       <= 4'd0;
                sel        <= 1'b0;
            end else begin
                stable_cnt <= stable_cnt_next;
                if (code_in != code_q) begin
                    acc_code <= BUS_INACTIVE;
                end
                if (accept) begin
                    acc_code <= code_in;
                end
                if (do_latch) begin
                    if (a_eff[7:4] == CHIP_SEL) begin
                        addr <= a_eff[3:0];
                        sel  <= 1'b1;
                    end else begin
                        sel  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (!psg_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (do_write) begin
            regs[addr] <= wdata_masked;
        end
    end

    // The register file still takes a write whose FIFO push is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fifo_count <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem[i] <= 12'h000;
            end
        end else if (!psg_rst_n) begin
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {addr, wdata_masked};
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (psg_rst_n && drop) begin
            overflow_q <= 1'b1;
        end
    end

    assign read_active   = (acc_code == BUS_READ) && sel;
    assign bus.data_oe   = read_active;
    assign bus.data_out  = read_active ? regs[addr] : 8'h00;
    assign bus.wr_valid  = (fifo_count != 3'd0);
    assign bus.wr_addr   = fifo_mem[rd_ptr][11:8];
    assign bus.wr_data   = fifo_mem[rd_ptr][7:0];
    assign bus.psg_reset = ~rst_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_mb_psg_bus_decoder.sv
// Testbench for mb_psg_bus_decoder: directed scenarios plus random bus traffic,
// all checked against a run-length/queue reference model every cycle.
module tb_mb_psg_bus_decoder;
    localparam int         S    = 2;
    localparam logic [3:0] CHIP = 4'h0;

    localparam logic [1:0] C_INACT = 2'b00;
    localparam logic [1:0] C_READ  = 2'b01;
    localparam logic [1:0] C_WRITE = 2'b10;
    localparam logic [1:0] C_LATCH = 2'b11;

    logic clock = 1'b0;
    logic reset_n;
    logic cmp_en = 1'b0;
    int   checks = 0;
    int   passes = 0;

    logic [7:0] a_drive = 8'hFF;
    logic [1:0] rnd_code;
    logic [7:0] rnd_data;
    int         rnd_len;

    mb_psg_bus_decoder_if bus();

    mb_psg_bus_decoder #(
        .CHIP_SEL      (CHIP),
        .STABLE_CYCLES (S)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Reference model: register file, selection, run length of the current code, FIFO queue.
    logic [7:0]  mask_table [16] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F, 8'hFF,
                                     8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'hFF};
    logic [7:0]  m_regs [16];
    logic [3:0]  m_addr;
    logic        m_sel;
    logic        m_in_read;
    logic        m_overflow;
    logic        m_psg_reset;
    logic [1:0]  m_last_code;
    int          m_run_len;
    logic [11:0] m_fifo [$];

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_addr      = 4'h0;
        m_sel       = 1'b0;
        m_in_read   = 1'b0;
        m_overflow  = 1'b0;
        m_psg_reset = 1'b1;
        m_last_code = C_INACT;
        m_run_len   = 1;
        m_fifo.delete();
    endtask

    task automatic model_step();
        logic [7:0] a;
        logic [2:0] b;
        logic [1:0] code;
        logic       do_pop;
        logic [7:0] wval;
        a      = bus.port_a_o | ~bus.port_a_t;
        b      = bus.port_b_o[2:0] | ~bus.port_b_t[2:0];
        code   = b[1:0];
        do_pop = (m_fifo.size() != 0) && bus.wr_ready;
        if (!b[2]) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_addr      = 4'h0;
            m_sel       = 1'b0;
            m_in_read   = 1'b0;
            m_psg_reset = 1'b1;
            m_last_code = code;
            m_run_len   = 1;
            m_fifo.delete();
        end else begin
            m_psg_reset = 1'b0;
            if (do_pop) void'(m_fifo.pop_front());
            if (code == m_last_code) begin
                m_run_len++;
            end else begin
                m_run_len = 1;
                m_in_read = 1'b0;
            end
            m_last_code = code;
            if (m_run_len == S) begin
                if (code == C_LATCH) begin
                    if (a[7:4] == CHIP) begin
                        m_addr = a[3:0];
                        m_sel  = 1'b1;
                    end else begin
                        m_sel = 1'b0;
                    end
                end else if (code == C_WRITE && m_sel) begin
                    wval           = a & mask_table[m_addr];
                    m_regs[m_addr] = wval;
                    if (m_fifo.size() < 4) m_fifo.push_back({m_addr, wval});
                    else m_overflow = 1'b1;
                end else if (code == C_READ) begin
                    m_in_read = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    function automatic logic [23:0] exp_vec();
        logic        oe;
        logic [11:0] head;
        oe   = m_in_read && m_sel;
        head = (m_fifo.size() != 0) ? m_fifo[0] : 12'h000;
        return {m_psg_reset, m_overflow, oe, (oe ? m_regs[m_addr] : 8'h00),
                (m_fifo.size() != 0), head};
    endfunction

    function automatic logic [23:0] act_vec();
        return {bus.psg_reset, bus.overflow, bus.data_oe, bus.data_out, bus.wr_valid,
                (bus.wr_valid ? {bus.wr_addr, bus.wr_data} : 12'h000)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    always @(negedge clock) begin
        if (reset_n && cmp_en) check_output("cycle_vs_model", 32'(act_vec()), 32'(exp_vec()));
    end

    task automatic apply_stimulus(input logic [1:0] code, input logic [7:0] data,
                                  input logic rst_pin, input int cycles);
        bus.port_a_o = data;
        bus.port_a_t = a_drive;
        bus.port_b_o = {5'b00000, rst_pin, code};
        bus.port_b_t = 8'h07;
        repeat (cycles) @(negedge clock);
    endtask

    initial begin
        bus.wr_ready = 1'b0;
        reset_n      = 1'b0;
        apply_stimulus(C_INACT, 8'h00, 1'b1, 3);
        check_output("reset_psg_reset", 32'(bus.psg_reset), 32'd1);
        check_output("reset_outputs", 32'({bus.overflow, bus.data_oe, bus.data_out,
                     bus.wr_valid, bus.wr_addr, bus.wr_data}), 32'd0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clock);
        check_output("psg_reset_release", 32'(bus.psg_reset), 32'd0);

        $display("[TB] latch R7, write 0xF8");
        apply_stimulus(C_LATCH, 8'h07, 1'b1, 3);
        apply_stimulus(C_WRITE, 8'hF8, 1'b1, 1);
        check_output("write_first_edge", 32'(bus.wr_valid), 32'd0);
        @(negedge clock);
        check_output("write_accept_edge", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
                     32'({1'b1, 4'h7, 8'hF8}));
        check_output("model_r7", 32'(m_regs[7]), 32'h0F8);
        check_output("model_fifo_one", 32'(m_fifo.size()), 32'd1);
        apply_stimulus(C_INACT, 8'h00, 1'b1, 2);
        bus.wr_ready = 1'b1;
        @(negedge clock);
        bus.wr_ready = 1'b0;
        check_output("drain_single", 32'(bus.wr_valid), 32'd0);

        $display("[TB] R13 masking and read-back");
        apply_stimulus(C_LATCH, 8'h0D, 1'b1, 3);
        apply_stimulus(C_WRITE, 8'hFF, 1'b1, 3);
        check_output("r13_fifo_masked", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
                     32'({1'b1, 4'hD, 8'h0F}));
        apply_stimulus(C_READ, 8'h00, 1'b1, 1);
        check_output("read_not_yet", 32'(bus.data_oe), 32'd0);
        @(negedge clock);
        check_output("r13_read", 32'({bus.data_oe, bus.data_out}), 32'({1'b1, 8'h0F}));
        apply_stimulus(C_INACT, 8'h00, 1'b1, 1);
        check_output("read_release", 32'(bus.data_oe), 32'd0);
        bus.wr_ready = 1'b1;
        @(negedge clock);
        bus.wr_ready = 1'b0;

        $display("[TB] unselected chip");
        apply_stimulus(C_LATCH, 8'h13, 1'b1, 3);
        apply_stimulus(C_WRITE, 8'h55, 1'b1, 3);
        check_output("unsel_no_push", 32'(bus.wr_valid), 32'd0);
        check_output("model_unsel", 32'(m_sel), 32'd0);
        apply_stimulus(C_READ, 8'h00, 1'b1, 3);
        check_output("unsel_no_read", 32'(bus.data_oe), 32'd0);
        apply_stimulus(C_INACT, 8'h00, 1'b1, 2);

        $display("[TB] FIFO full with wr_ready low");
        apply_stimulus(C_LATCH, 8'h02, 1'b1, 3);
        for (int i = 1; i <= 5; i++) begin
            apply_stimulus(C_WRITE, 8'(i), 1'b1, 3);
            apply_stimulus(C_INACT, 8'h00, 1'b1, 2);
        end
        check_output("overflow_set", 32'(bus.overflow), 32'd1);
        check_output("model_fifo_four", 32'(m_fifo.size()), 32'd4);
        apply_stimulus(C_READ, 8'h00, 1'b1, 3);
        check_output("reg_holds_fifth", 32'({bus.data_oe, bus.data_out}), 32'({1'b1, 8'h05}));
        apply_stimulus(C_INACT, 8'h00, 1'b1, 1);
        bus.wr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check_output("drain_order", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
                         32'({1'b1, 4'h2, 8'(i)}));
            @(negedge clock);
        end
        bus.wr_ready = 1'b0;
        check_output("drained_empty", 32'(bus.wr_valid), 32'd0);

        $display("[TB] glitch and long hold");
        apply_stimulus(C_WRITE, 8'hAA, 1'b1, 1);
        apply_stimulus(C_INACT, 8'h00, 1'b1, 3);
        check_output("glitch_no_push", 32'(bus.wr_valid), 32'd0);
        apply_stimulus(C_WRITE, 8'h3C, 1'b1, 10);
        check_output("hold_one_push", 32'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
                     32'({1'b1, 4'h2, 8'h3C}));
        apply_stimulus(C_INACT, 8'h00, 1'b1, 1);
        bus.wr_ready = 1'b1;
        @(negedge clock);
        bus.wr_ready = 1'b0;
        check_output("hold_only_one", 32'(bus.wr_valid), 32'd0);

        $display("[TB] PSG reset via PB2");
        apply_stimulus(C_LATCH, 8'h04, 1'b1, 3);
        apply_stimulus(C_WRITE, 8'h77, 1'b1, 3);
        apply_stimulus(C_INACT, 8'h00, 1'b1, 1);
        apply_stimulus(C_INACT, 8'h00, 1'b0, 3);
        check_output("pb2_psg_reset", 32'({bus.psg_reset, bus.overflow, bus.wr_valid}),
                     32'({1'b1, 1'b1, 1'b0}));
        check_output("model_r4_cleared", 32'(m_regs[4]), 32'd0);
        apply_stimulus(C_INACT, 8'h00, 1'b1, 2);
        check_output("pb2_release", 32'(bus.psg_reset), 32'd0);
        apply_stimulus(C_LATCH, 8'h04, 1'b1, 3);
        apply_stimulus(C_READ, 8'h00, 1'b1, 3);
        check_output("r4_reads_zero", 32'({bus.data_oe, bus.data_out}), 32'({1'b1, 8'h00}));
        apply_stimulus(C_INACT, 8'h00, 1'b1, 2);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check_output("reset_n_clears_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clock);

        $display("[TB] random traffic");
        for (int n = 0; n < 500; n++) begin
            rnd_code     = 2'($urandom_range(0, 3));
            rnd_data     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {4'h0, 4'($urandom)};
            rnd_len      = $urandom_range(1, 4);
            a_drive      = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
            bus.wr_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 40) == 0) apply_stimulus(C_INACT, rnd_data, 1'b0, rnd_len);
            else apply_stimulus(rnd_code, rnd_data, 1'b1, rnd_len);
        end
        a_drive = 8'hFF;
        apply_stimulus(C_INACT, 8'h00, 1'b1, 4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
